// File: rtl/md5_pad_block.sv
// md5_pad_block: assembles MD5 512-bit blocks from a byte stream with terminator, zero fill and bit length
module md5_pad_block #(
  parameter int n     = 32,
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   data_i,
  input  logic         valid_i,
  input  logic         last_i,
  output logic         ready_o,
  output logic [n-1:0] M_o [0:15],
  output logic         blk_valid_o,
  output logic         blk_last_o,
  input  logic         blk_ready_i
);
  typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;
  state_t state_q, state_d;
  logic [5:0] pos_q, pos_d;
  logic [60:0] bytes_q, bytes_d;
  logic last_q, last_d;
  logic pad_q, pad_d;
  logic len_q, len_d;
  logic [7:0] buf_q [64];
  logic [7:0] buf_d [64];
  logic [LEN_W-1:0] bitlen;
  assign bitlen = {bytes_q, 3'b000};
  assign ready_o = (state_q == FILL) && !rst_i;
  assign blk_valid_o = state_q == EMIT;
  assign blk_last_o = last_q;
  // little-endian packing of buffer bytes into block words
  always_comb begin
    for (int w = 0; w < 16; w++) M_o[w] = {buf_q[4*w+3], buf_q[4*w+2], buf_q[4*w+1], buf_q[4*w]};
  end
  // next-state: byte fill, terminator/length padding, block hand-off
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    bytes_d = bytes_q;
    last_d  = last_q;
    pad_d   = pad_q;
    len_d   = len_q;
    buf_d   = buf_q;
    case (state_q)
      FILL: if (valid_i) begin
        buf_d[pos_q] = data_i;
        pos_d = pos_q + 6'd1;
        bytes_d = bytes_q + 61'd1;
        if (pos_q == 6'd63) begin
          state_d = EMIT;
          last_d = 1'b0;
          pad_d = last_i;
        end else if (last_i) state_d = PAD;
      end
      PAD: begin
        for (int k = 0; k < 64; k++)
          buf_d[k] = (6'(k) == pos_q) ? 8'h80 : (6'(k) > pos_q) ? 8'h00 : buf_q[k];
        if (pos_q <= 6'd55)
          for (int k = 56; k < 64; k++) buf_d[k] = bitlen[8*(k-56) +: 8];
        state_d = EMIT;
        last_d = pos_q <= 6'd55;
        len_d = pos_q > 6'd55;
        pad_d = 1'b0;
      end
      LEN: begin
        for (int k = 0; k < 56; k++) buf_d[k] = 8'h00;
        for (int k = 56; k < 64; k++) buf_d[k] = bitlen[8*(k-56) +: 8];
        state_d = EMIT;
        last_d = 1'b1;
        len_d = 1'b0;
      end
      EMIT: if (blk_ready_i) begin
        state_d = last_q ? FILL : pad_q ? PAD : len_q ? LEN : FILL;
        pos_d = 6'd0;
        bytes_d = last_q ? 61'd0 : bytes_q;
        last_d = 1'b0;
      end
      default: state_d = FILL;
    endcase
  end
  // state registers with synchronous reset discarding any partial message
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      pos_q   <= '0;
      bytes_q <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
      len_q   <= 1'b0;
      buf_q   <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      bytes_q <= bytes_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
    end
  end
endmodule
